// File: rtl/tx_frame_serializer.sv
// Frame serializer: reads the Y/C one-bit frame buffer and sends frame sync, line syncs
// and data bits as a fixed-rate NRZ stream with a one-bit read prefetch.
module tx_frame_serializer #(
  parameter int unsigned BIT_TIME  = 25,
  parameter int unsigned LINE_BITS = 160,
  parameter int unsigned LINES     = 480,
  parameter logic [23:0] FRAME1    = 24'hAAB155,
  parameter logic [23:0] FRAME0    = 24'hAA8D55,
  parameter logic [7:0]  HSYNC     = 8'h55
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Start,
  input  logic        Abort,
  output logic        ReadTxY,
  output logic        ReadTxC,
  output logic [16:0] ReadTxAdd,
  input  logic        ReadTxData,
  output logic        TxBit,
  output logic [5:0]  TxData,
  output logic        Busy,
  output logic        FrameDone,
  output logic        FrameOdd
);

  localparam logic [23:0] LSYNC_WORD = {16'h0000, HSYNC};
  localparam logic [7:0]  BT_LAST    = 8'(BIT_TIME - 1);
  localparam logic [7:0]  BT_CAP     = 8'(BIT_TIME - 2);
  localparam logic [7:0]  BT_FETCH   = 8'(BIT_TIME - 4);
  localparam logic [7:0]  LB_LAST    = 8'(LINE_BITS - 1);
  localparam logic [8:0]  LN_LAST    = 9'(LINES - 1);
  localparam logic [4:0]  SYNC_LAST  = 5'd23;

  typedef enum logic [1:0] {S_IDLE, S_FSYNC, S_LSYNC, S_DATA} state_t;

  state_t      state_q;
  logic [7:0]  bitcnt_q;
  logic [4:0]  sbit_q;
  logic [7:0]  lbit_q;
  logic [8:0]  line_q;
  logic [16:0] p_q;
  logic [22:0] sh_q;
  logic        data_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        odd_q;
  logic        rdy_q;
  logic        rdc_q;
  logic [16:0] addr_q;

  logic        fetch_c;
  logic [23:0] fsync_word_c;

  // A data sample is fetched one bit ahead: in the last line-sync bit or any non-final data bit.
  assign fetch_c = ((state_q == S_LSYNC) && (sbit_q == SYNC_LAST)) ||
                   ((state_q == S_DATA) && (lbit_q != LB_LAST));
  assign fsync_word_c = odd_q ? FRAME0 : FRAME1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      sbit_q   <= '0;
      lbit_q   <= '0;
      line_q   <= '0;
      p_q      <= '0;
      sh_q     <= '0;
      data_q   <= 1'b0;
      tx_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      odd_q    <= 1'b0;
      rdy_q    <= 1'b0;
      rdc_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
      rdc_q  <= 1'b0;
      if (Abort) begin
        state_q  <= S_IDLE;
        bitcnt_q <= '0;
        sbit_q   <= '0;
        lbit_q   <= '0;
        line_q   <= '0;
        p_q      <= '0;
        tx_q     <= 1'b0;
        busy_q   <= 1'b0;
      end else if (state_q == S_IDLE) begin
        if (Start) begin
          state_q  <= S_FSYNC;
          bitcnt_q <= '0;
          sbit_q   <= '0;
          lbit_q   <= '0;
          line_q   <= '0;
          p_q      <= '0;
          sh_q     <= fsync_word_c[22:0];
          tx_q     <= fsync_word_c[23];
          busy_q   <= 1'b1;
        end
      end else begin
        bitcnt_q <= (bitcnt_q == BT_LAST) ? 8'd0 : bitcnt_q + 8'd1;

        if ((bitcnt_q == BT_FETCH) && fetch_c) begin
          rdy_q  <= ~p_q[0];
          rdc_q  <= p_q[0];
          addr_q <= {1'b0, p_q[16:1]};
          p_q    <= p_q + 17'd1;
        end

        if (bitcnt_q == BT_CAP) begin
          data_q <= ReadTxData;
        end

        // Bit boundary: choose the next bit to drive and advance the framing counters.
        if (bitcnt_q == BT_LAST) begin
          case (state_q)
            S_FSYNC, S_LSYNC: begin
              if (sbit_q == SYNC_LAST) begin
                sbit_q <= '0;
                if (state_q == S_FSYNC) begin
                  state_q <= S_LSYNC;
                  sh_q    <= LSYNC_WORD[22:0];
                  tx_q    <= LSYNC_WORD[23];
                end else begin
                  state_q <= S_DATA;
                  lbit_q  <= '0;
                  tx_q    <= data_q;
                end
              end else begin
                sbit_q <= sbit_q + 5'd1;
                sh_q   <= {sh_q[21:0], 1'b0};
                tx_q   <= sh_q[22];
              end
            end
            S_DATA: begin
              if (lbit_q == LB_LAST) begin
                lbit_q <= '0;
                if (line_q == LN_LAST) begin
                  state_q <= S_IDLE;
                  line_q  <= '0;
                  p_q     <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  odd_q   <= ~odd_q;
                end else begin
                  state_q <= S_LSYNC;
                  line_q  <= line_q + 9'd1;
                  sh_q    <= LSYNC_WORD[22:0];
                  tx_q    <= LSYNC_WORD[23];
                end
              end else begin
                lbit_q <= lbit_q + 8'd1;
                tx_q   <= data_q;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign ReadTxY   = rdy_q;
  assign ReadTxC   = rdc_q;
  assign ReadTxAdd = addr_q;
  assign TxBit     = tx_q;
  assign TxData    = {6{tx_q}};
  assign Busy      = busy_q;
  assign FrameDone = done_q;
  assign FrameOdd  = odd_q;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Randomized bench for tx_frame_serializer on a small frame, checked against a
// stream/fetch-schedule model built directly from the framing rules.
module tb_tx_frame_serializer;

  localparam int unsigned BT   = 4;
  localparam int unsigned LB   = 8;
  localparam int unsigned NL   = 2;
  localparam int unsigned MEMN = (LB * NL) / 2;
  localparam logic [23:0] F1   = 24'hAAB155;
  localparam logic [23:0] F0   = 24'hAA8D55;
  localparam logic [7:0]  HS   = 8'h55;

  logic        clk = 1'b0;
  logic        rstn;
  logic        Start;
  logic        Abort;
  logic        ReadTxY;
  logic        ReadTxC;
  logic [16:0] ReadTxAdd;
  logic        ReadTxData = 1'b0;
  logic        TxBit;
  logic [5:0]  TxData;
  logic        Busy;
  logic        FrameDone;
  logic        FrameOdd;

  tx_frame_serializer #(
    .BIT_TIME(BT), .LINE_BITS(LB), .LINES(NL),
    .FRAME1(F1), .FRAME0(F0), .HSYNC(HS)
  ) dut (
    .clk(clk), .rstn(rstn), .Start(Start), .Abort(Abort),
    .ReadTxY(ReadTxY), .ReadTxC(ReadTxC), .ReadTxAdd(ReadTxAdd),
    .ReadTxData(ReadTxData), .TxBit(TxBit), .TxData(TxData),
    .Busy(Busy), .FrameDone(FrameDone), .FrameOdd(FrameOdd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit y;
    int addr;
  } strobe_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  bit      exp_odd  = 1'b0;
  bit      ymem [MEMN];
  bit      cmem [MEMN];
  strobe_t strobe_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: returns data the cycle after a strobe, noise otherwise.
  always @(posedge clk) begin
    if (ReadTxY && (int'(ReadTxAdd) < MEMN))      ReadTxData <= ymem[int'(ReadTxAdd)];
    else if (ReadTxC && (int'(ReadTxAdd) < MEMN)) ReadTxData <= cmem[int'(ReadTxAdd)];
    else                                          ReadTxData <= 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (ReadTxY || ReadTxC) begin
      strobe_t r;
      check_eq("strobe_exclusive", 32'(ReadTxY & ReadTxC), 32'd0);
      r.cyc  = cyc;
      r.y    = ReadTxY;
      r.addr = int'(ReadTxAdd);
      strobe_q.push_back(r);
    end
  end

  task automatic fill_mem(input int mode);
    for (int i = 0; i < MEMN; i++) begin
      case (mode)
        0:       begin ymem[i] = 1'b0; cmem[i] = 1'b0; end
        1:       begin ymem[i] = 1'b1; cmem[i] = 1'b0; end
        default: begin ymem[i] = 1'($urandom_range(0, 1)); cmem[i] = 1'($urandom_range(0, 1)); end
      endcase
    end
  endtask

  function automatic int data_bit_index(input int p);
    return 24 + (p / LB) * (24 + LB) + 24 + (p % LB);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_txbit"}, 32'(TxBit), 32'd0);
    check_eq({tag, "_txdata"}, 32'(TxData), 32'd0);
    check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
    check_eq({tag, "_done"}, 32'(FrameDone), 32'd0);
    check_eq({tag, "_odd"}, 32'(FrameOdd), 32'd0);
    check_eq({tag, "_rdy"}, 32'(ReadTxY), 32'd0);
    check_eq({tag, "_rdc"}, 32'(ReadTxC), 32'd0);
    check_eq({tag, "_addr"}, 32'(ReadTxAdd), 32'd0);
  endtask

  // Called at a negedge while idle. stop_mode: 0 full frame, 1 abort at stop_cyc, 2 reset at stop_cyc.
  task automatic run_frame(input int stop_mode, input int stop_cyc, input bit hold_start);
    logic [23:0] fs;
    logic [23:0] ls;
    bit          expq [$];
    int          ncyc;
    int          t0;
    int          last;
    int          n_exp;
    int          p;
    strobe_t     r;

    fs = exp_odd ? F0 : F1;
    ls = {16'h0000, HS};
    expq.delete();
    for (int b = 23; b >= 0; b--) expq.push_back(fs[b]);
    for (int l = 0; l < NL; l++) begin
      for (int b = 23; b >= 0; b--) expq.push_back(ls[b]);
      for (int b = 0; b < LB; b++) begin
        p = l * LB + b;
        expq.push_back((p % 2 == 0) ? ymem[p / 2] : cmem[p / 2]);
      end
    end
    ncyc = expq.size() * BT;
    last = ncyc;
    t0   = 0;

    check_eq("idle_no_strobes", 32'(strobe_q.size()), 32'd0);
    strobe_q.delete();
    check_eq("odd_before", 32'(FrameOdd), 32'(exp_odd));

    Start = 1'b1;
    for (int i = 0; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc;
      if (i == ncyc) begin
        exp_odd = ~exp_odd;
        check_eq("end_done", 32'(FrameDone), 32'd1);
        check_eq("end_busy", 32'(Busy), 32'd0);
        check_eq("end_txbit", 32'(TxBit), 32'd0);
        check_eq("end_odd", 32'(FrameOdd), 32'(exp_odd));
        Start = hold_start;
      end else begin
        check_eq("txbit", 32'(TxBit), 32'(expq[i / BT]));
        check_eq("txdata", 32'(TxData), 32'({6{expq[i / BT]}}));
        check_eq("busy", 32'(Busy), 32'd1);
        check_eq("done_low", 32'(FrameDone), 32'd0);
        Start = hold_start ? 1'b1 : 1'($urandom_range(0, 7) == 0);
        if (stop_mode != 0 && i == stop_cyc) begin
          last  = i;
          Start = 1'b0;
          if (stop_mode == 1) begin
            Abort = 1'b1;
            @(negedge clk);
            Abort = 1'b0;
            check_eq("abort_txbit", 32'(TxBit), 32'd0);
            check_eq("abort_busy", 32'(Busy), 32'd0);
            check_eq("abort_done", 32'(FrameDone), 32'd0);
            check_eq("abort_odd", 32'(FrameOdd), 32'(exp_odd));
          end else begin
            #2 rstn = 1'b0;
            #1 check_outputs_zero("async_rst");
            exp_odd = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
          end
          break;
        end
      end
    end

    // Expected fetch schedule: sample p is strobed at bitcnt BT-3 of the bit before it.
    n_exp = 0;
    for (int q = 0; q < LB * NL; q++) begin
      if ((data_bit_index(q) - 1) * BT + BT - 3 <= last) n_exp++;
    end
    check_eq("strobe_count", 32'(strobe_q.size()), 32'(n_exp));
    for (int q = 0; q < n_exp && strobe_q.size() > 0; q++) begin
      r = strobe_q.pop_front();
      check_eq("strobe_cycle", 32'(r.cyc - t0), 32'((data_bit_index(q) - 1) * BT + BT - 3));
      check_eq("strobe_y", 32'(r.y), 32'(q % 2 == 0));
      check_eq("strobe_addr", 32'(r.addr), 32'(q / 2));
    end
    strobe_q.delete();
  endtask

  initial begin
    rstn  = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_txbit", 32'(TxBit), 32'd0);

    // All-zero buffer, even frame.
    run_frame(0, 0, 1'b0);
    repeat (3) @(negedge clk);

    // Y=1/C=0 with Start held: back-to-back odd then even frame.
    fill_mem(1);
    run_frame(0, 0, 1'b1);
    run_frame(0, 0, 1'b0);
    repeat (3) @(negedge clk);

    // Abort at line 1 bit 5, on a bit boundary just before a fetch, then restart.
    fill_mem(2);
    run_frame(1, data_bit_index(LB + 5) * BT, 1'b0);
    repeat (4) @(negedge clk);
    fill_mem(2);
    run_frame(0, 0, 1'b0);
    repeat (2) @(negedge clk);

    // Start together with Abort in idle must not start a frame.
    Start = 1'b1;
    Abort = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    Abort = 1'b0;
    check_eq("start_abort_busy", 32'(Busy), 32'd0);
    check_eq("start_abort_txbit", 32'(TxBit), 32'd0);
    @(negedge clk);
    check_eq("start_abort_busy2", 32'(Busy), 32'd0);

    // Full frame to make FrameOdd=1, then async reset mid-frame and a clean frame after.
    fill_mem(2);
    run_frame(0, 0, 1'b0);
    repeat (2) @(negedge clk);
    fill_mem(2);
    run_frame(2, (24 + 24 + LB + 10) * BT + 2, 1'b0);
    repeat (5) @(negedge clk);
    fill_mem(2);
    run_frame(0, 0, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("final_no_strobes", 32'(strobe_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_serializer.md
# tx_frame_serializer

Transmit-side counterpart of the camera-link frame receiver. It reads a 1-bit-per-sample Y/C frame buffer and serializes it onto the link as a fixed-rate NRZ bitstream. Each frame starts with a 24-bit frame sync, and every line is preceded by a 24-bit line sync. The 6-bit level output drives the same link front end that the receiver samples, where level > 0x1F reads as 1.

## Interface
- BIT_TIME, 25: clocks per transmitted bit, minimum 4.
- LINE_BITS, 160: data bits per line.
- LINES, 480: lines per frame. LINE_BITS*LINES must be ≤ 131072.
- FRAME1, 24'hAAB155: frame sync for even frames.
- FRAME0, 24'hAA8D55: frame sync for odd frames.
- HSYNC, 8'h55: line sync low byte. The line sync word is {16'h0000, HSYNC}.

- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- Start  in  1  frame request; sampled only in IDLE.
- Abort  in  1  synchronous abort; forces IDLE next cycle.
- ReadTxY  out  1  read strobe, Y buffer.
- ReadTxC  out  1  read strobe, C buffer.
- ReadTxAdd  out  17  buffer address = sample index >> 1.
- ReadTxData  in  1  read data, valid exactly 1 cycle after a strobe.
- TxBit  out  1  serialized bit.
- TxData  out  6  link level: 6'h3F when TxBit=1, 6'h00 when TxBit=0.
- Busy  out  1  frame in progress.
- FrameDone  out  1  one-cycle pulse at normal end of frame.
- FrameOdd  out  1  parity of the next or current frame; 0 means even, which uses FRAME1.

## Operation
- States:
  - IDLE → FSYNC on Start.
  - FSYNC, 24 bits → LSYNC.
  - LSYNC, 24 bits → DATA.
  - DATA, LINE_BITS bits → LSYNC, or → IDLE after line LINES-1.
- Abort in any state → IDLE.
- Sync words are sent MSB first. FSYNC sends FRAME1 if FrameOdd=0, else FRAME0.
- Sample index p = line*LINE_BITS + bit, running 0 .. LINE_BITS*LINES-1. Even p reads Y, odd p reads C; ReadTxAdd = p[16:1].
- Prefetch: the read for a bit is strobed in the previous bit period at bitcnt == BIT_TIME-3. Data is captured at BIT_TIME-2 and driven on TxBit at the next bit boundary.
  - For DATA bit 0, the fetch happens during the last LSYNC bit.
  - At most one of ReadTxY/ReadTxC is high, for exactly 1 cycle per data bit. There are no strobes outside these fetches.
- At the end of the last DATA bit of line LINES-1:
  - FrameDone=1 for 1 cycle, Busy→0, TxBit→0.
  - FrameOdd toggles.
  - State → IDLE.
- Abort: TxBit→0, Busy→0, no FrameDone, FrameOdd unchanged, no further strobes. The next Start restarts at FSYNC with p=0.
- Start while Busy is ignored. Start and Abort together in IDLE: Abort wins, so the block stays IDLE.
- In IDLE, TxBit=0 continuously.
- Counters:
  - bitcnt is 8 bits, 0..BIT_TIME-1.
  - Sync bit counter is 5 bits.
  - Line bit counter is 8 bits.
  - Line counter is 9 bits.
  - p is 17 bits and wraps to 0 on frame end or abort.

## Timing
- Reset values:
  - TxBit=0, TxData=0, Busy=0, FrameDone=0, FrameOdd=0.
  - ReadTxY=0, ReadTxC=0, ReadTxAdd=0.
  - State IDLE, all counters 0.
- All outputs are registered.
- Start sampled high at edge N: Busy=1 and TxBit = first FSYNC bit from edge N+1.
- Every bit holds exactly BIT_TIME cycles. Bit boundaries are contiguous across FSYNC/LSYNC/DATA with no gap cycles.
- Frame length = (24 + LINES*(24+LINE_BITS)) * BIT_TIME cycles. With defaults this is 88344 bits = 2,208,600 cycles.
- FrameDone asserts in the cycle after the last data bit's final cycle. That is the same edge where Busy falls and TxBit→0.
- Earliest next frame: Start in the cycle FrameDone is high is accepted, since the state is already IDLE. First bit appears the following cycle.
- Abort sampled at edge N: IDLE with TxBit=0 at N+1. A ReadTxData return at N+1 is discarded.

## Test plan
- Reset: assert rstn low mid-frame → all outputs 0 within the same cycle (async); no strobes until the next Start.
- Even frame, all-zero buffer, BIT_TIME=25:
  - Start → first 24 bits = AAB155 (MSB first), each 25 cycles.
  - Then 16 zeros + 0x55, then 160 zeros.
  - FrameDone after 2,208,600 cycles.
- Y buffer all 1, C buffer all 0:
  - DATA bits alternate 1,0,1,0…, TxData alternating 3F/00.
  - Strobes alternate Y/C.
  - ReadTxAdd sequence 0,0,1,1,…,38399,38399, with p=0 at line 0 bit 0 and p=159 at line 0 bit 159.
- Back-to-back frames: Start held high → second frame uses FRAME0 (AA8D55), third uses FRAME1. Start pulses during Busy have no effect.
- Abort at line 3, bit 50:
  - Next cycle: TxBit=0, Busy=0, no FrameDone, no strobes.
  - Restart sends the same frame sync (FrameOdd unchanged), with ReadTxAdd beginning at 0.
- BIT_TIME=4, LINE_BITS=8, LINES=2:
  - Read strobe at bitcnt 1, data captured at bitcnt 2.
  - Frame = (24+2*32)*4 = 352 cycles.
  - Compare the serialized stream bit-exact against a reference model.
